// File: rtl/stage_sequencer_if.sv
// Bundle of the stage sequencer's control inputs and pipeline-facing outputs.
// Combinational wiring only; no storage.
// No backpressure; the sequencer consumes inputs every cycle.
interface stage_sequencer_if #(
    parameter int STAGES = 5
);
    logic              alive;
    logic              mode;
    logic              stall;
    logic              flush;
    logic              halt_in;
    logic [STAGES-1:0] stage_en;
    logic [STAGES-1:0] stage_valid;
    logic              halt;
    logic [31:0]       retire_count;
    logic [15:0]       stall_count;

    // Pipeline/control side: drives requests, observes enables and status.
    modport master (
        output alive, mode, stall, flush, halt_in,
        input  stage_en, stage_valid, halt, retire_count, stall_count
    );

    // Sequencer side.
    modport slave (
        input  alive, mode, stall, flush, halt_in,
        output stage_en, stage_valid, halt, retire_count, stall_count
    );
endinterface

// File: rtl/stage_sequencer.sv
// Per-stage enable and valid tracking for the pipeline, sequential or overlapped.
// stage_en is combinational from state and stall/flush/halt; all state updates next clk.
// stall freezes front stages and inserts a bubble; halt freezes everything until reset.
module stage_sequencer #(
    parameter int STAGES       = 5,
    parameter int STALL_STAGES = 2,
    parameter int FLUSH_STAGES = 2
) (
    input logic              clk,
    input logic              rst,
    stage_sequencer_if.slave bus
);
    localparam int PW = (STAGES > 1) ? $clog2(STAGES) : 1;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } run_state_t;

    run_state_t        state_q, state_d;
    logic              mode_q;
    logic [PW-1:0]     phase_q, phase_d;
    logic [STAGES-1:0] valid_q, valid_d;
    logic [STAGES-1:0] en;
    logic [31:0]       retire_q, retire_d;
    logic [15:0]       stall_q, stall_d;
    logic              in_reset;
    logic              count_stall;
    logic              retire;

    // alive low behaves exactly like rst
    assign in_reset = rst || !bus.alive;

    // Next-state, stage enables and counter updates
    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        valid_d     = valid_q;
        retire_d    = retire_q;
        stall_d     = stall_q;
        en          = '0;
        count_stall = 1'b0;
        retire      = 1'b0;
        if (!in_reset && state_q == ST_RUN) begin
            if (!mode_q) begin
                // Sequential: one stage per cycle; flush wins over stall,
                // and stall only bites when fetch (phase 0) is active.
                if (bus.flush) begin
                    en[phase_q] = 1'b1;
                    phase_d     = '0;
                end else if (bus.stall && phase_q == '0) begin
                    count_stall = 1'b1;
                end else begin
                    en[phase_q] = 1'b1;
                    phase_d     = (phase_q == PW'(STAGES - 1)) ? '0 : phase_q + 1'b1;
                end
                // stage_valid mirrors the phase that will be active next cycle
                valid_d          = '0;
                valid_d[phase_d] = 1'b1;
            end else begin
                // Overlapped: every stage advances, new fetch enters stage 0.
                en      = '1;
                valid_d = {valid_q[STAGES-2:0], 1'b1};
                if (bus.flush) begin
                    // Wrong-path instructions younger than the branch die.
                    for (int i = 1; i <= FLUSH_STAGES; i++) begin
                        valid_d[i] = 1'b0;
                    end
                end else if (bus.stall) begin
                    // Front stages freeze; a bubble enters the first free stage.
                    for (int i = 0; i < STALL_STAGES; i++) begin
                        en[i]      = 1'b0;
                        valid_d[i] = valid_q[i];
                    end
                    valid_d[STALL_STAGES] = 1'b0;
                    count_stall           = 1'b1;
                end
            end

            retire = en[STAGES-1] && valid_q[STAGES-1];
            if (retire) begin
                retire_d = retire_q + 32'd1;
                if (bus.halt_in) begin
                    state_d = ST_HALTED;
                end
            end
            if (count_stall && stall_q != 16'hFFFF) begin
                stall_d = stall_q + 16'd1;
            end
        end
    end

    // State register with synchronous reset; mode is latched only in reset
    always_ff @(posedge clk) begin
        if (in_reset) begin
            state_q  <= ST_RUN;
            mode_q   <= bus.mode;
            phase_q  <= '0;
            valid_q  <= '0;
            retire_q <= '0;
            stall_q  <= '0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            valid_q  <= valid_d;
            retire_q <= retire_d;
            stall_q  <= stall_d;
        end
    end

    assign bus.stage_en     = en;
    assign bus.stage_valid  = valid_q;
    assign bus.halt         = (state_q == ST_HALTED);
    assign bus.retire_count = retire_q;
    assign bus.stall_count  = stall_q;
endmodule

// File: tb/tb_stage_sequencer.sv
// Self-checking bench for stage_sequencer against a behavioural pipeline model.
// One step per clock: inputs driven at negedge, outputs checked 1ns later.
// Directed scenarios followed by randomized stall/flush/halt/reset traffic.
module tb_stage_sequencer;
    localparam int STAGES = 5;
    localparam int S      = 2;
    localparam int F      = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_assert = 0;
    int   n_fail   = 0;

    stage_sequencer_if #(.STAGES(STAGES)) bus ();

    stage_sequencer #(
        .STAGES(STAGES), .STALL_STAGES(S), .FLUSH_STAGES(F)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    // Behavioural model: which stage holds a real instruction, plus counters.
    bit          m_mode;
    int          m_phase;
    bit          m_v[STAGES];
    bit          m_halt;
    logic [31:0] m_ret;
    int          m_stl;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [STAGES-1:0] m_valid_vec();
        logic [STAGES-1:0] r;
        for (int i = 0; i < STAGES; i++) r[i] = m_v[i];
        return r;
    endfunction

    function automatic logic [STAGES-1:0] exp_en(input bit r, input bit a, input bit st, input bit fl);
        logic [STAGES-1:0] e;
        e = '0;
        if (r || !a || m_halt) return e;
        if (!m_mode) begin
            if (fl || !(st && m_phase == 0)) e[m_phase] = 1'b1;
        end else begin
            e = '1;
            if (st && !fl) for (int i = 0; i < S; i++) e[i] = 1'b0;
        end
        return e;
    endfunction

    // One clock: drive, check current outputs, then advance the model.
    task automatic step(input bit r, input bit a, input bit md, input bit st, input bit fl, input bit hi);
        logic [STAGES-1:0] e;
        bit nv[STAGES];
        @(negedge clk);
        rst = r; bus.alive = a; bus.mode = md; bus.stall = st; bus.flush = fl; bus.halt_in = hi;
        #1;
        e = exp_en(r, a, st, fl);
        chk("stage_en", 32'(bus.stage_en), 32'(e));
        chk("stage_valid", 32'(bus.stage_valid), 32'(m_valid_vec()));
        chk("halt", 32'(bus.halt), 32'(m_halt));
        chk("retire_count", bus.retire_count, m_ret);
        chk("stall_count", 32'(bus.stall_count), 32'(m_stl));
        if (r || !a) begin
            m_mode = md; m_phase = 0; m_halt = 0; m_ret = '0; m_stl = 0;
            for (int i = 0; i < STAGES; i++) m_v[i] = 0;
        end else if (!m_halt) begin
            if (e[STAGES-1] && m_v[STAGES-1]) begin
                m_ret = m_ret + 1;
                if (hi) m_halt = 1;
            end
            if (!m_mode) begin
                if (fl) m_phase = 0;
                else if (st && m_phase == 0) m_stl = (m_stl < 65535) ? m_stl + 1 : 65535;
                else m_phase = (m_phase + 1) % STAGES;
                for (int i = 0; i < STAGES; i++) m_v[i] = (i == m_phase);
            end else begin
                for (int i = 0; i < STAGES; i++) begin
                    if (fl)                 nv[i] = (i == 0) ? 1'b1 : (i <= F) ? 1'b0 : m_v[i-1];
                    else if (st && i < S)   nv[i] = m_v[i];
                    else if (st && i == S)  nv[i] = 1'b0;
                    else                    nv[i] = (i == 0) ? 1'b1 : m_v[i-1];
                end
                if (st && !fl) m_stl = (m_stl < 65535) ? m_stl + 1 : 65535;
                m_v = nv;
            end
        end
    endtask

    logic [31:0] ret_snap;
    int          stl_snap;

    initial begin
        bus.alive = 1'b1; bus.mode = 1'b0; bus.stall = 1'b0; bus.flush = 1'b0; bus.halt_in = 1'b0;
        m_mode = 0; m_phase = 0; m_halt = 0; m_ret = '0; m_stl = 0;
        for (int i = 0; i < STAGES; i++) m_v[i] = 0;

        // Reset into sequential mode
        step(1, 1, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0);

        // Sequential rotation, 10 active cycles, 2 retires
        for (int i = 0; i < 10; i++) begin
            step(0, 1, 0, 0, 0, 0);
            chk("seq_onehot", 32'(bus.stage_en), 32'(1) << (i % STAGES));
        end
        step(0, 1, 1, 0, 0, 0);
        chk("seq_retire_10", bus.retire_count, 32'd2);

        // Sequential random stall/flush; mode input wiggles but is ignored
        for (int i = 0; i < 60; i++)
            step(0, 1, 1'($urandom), ($urandom_range(0, 2) == 0), ($urandom_range(0, 6) == 0), 0);

        // Overlapped fill
        step(1, 1, 1, 0, 0, 0);
        for (int k = 0; k < 6; k++) begin
            step(0, 1, 1, 0, 0, 0);
            chk("ovl_fill", 32'(bus.stage_valid), (32'(1) << k) - 1);
        end
        ret_snap = bus.retire_count;
        for (int k = 0; k < 3; k++) step(0, 1, 1, 0, 0, 0);
        chk("ovl_throughput", bus.retire_count - ret_snap, 32'd3);

        // Two stall cycles at steady state
        stl_snap = int'(bus.stall_count);
        step(0, 1, 1, 1, 0, 0);
        chk("stall_en_1", 32'(bus.stage_en), 32'b11100);
        step(0, 1, 1, 1, 0, 0);
        chk("stall_en_2", 32'(bus.stage_en), 32'b11100);
        chk("stall_bubble_1", 32'(bus.stage_valid), 32'b11011);
        step(0, 1, 1, 0, 0, 0);
        chk("stall_count_2", 32'(bus.stall_count) - 32'(stl_snap), 32'd2);
        for (int k = 0; k < 6; k++) step(0, 1, 1, 0, 0, 0);

        // Flush with simultaneous stall
        stl_snap = int'(bus.stall_count);
        step(0, 1, 1, 1, 1, 0);
        chk("flush_en", 32'(bus.stage_en), 32'b11111);
        step(0, 1, 1, 0, 0, 0);
        chk("flush_valid", 32'(bus.stage_valid), 32'b11001);
        chk("flush_no_stall_cnt", 32'(bus.stall_count), 32'(stl_snap));

        // Random overlapped traffic, no halt
        for (int i = 0; i < 200; i++)
            step(0, 1, 0, ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0), 0);

        // Halt: ignored on a bubble, taken on a valid last stage
        for (int k = 0; k < 6; k++) step(0, 1, 1, 0, 0, 0);
        step(0, 1, 1, 1, 0, 0);
        step(0, 1, 1, 0, 0, 0);
        step(0, 1, 1, 0, 0, 0);
        step(0, 1, 1, 0, 0, 1);
        chk("halt_bubble_valid", 32'(bus.stage_valid), 32'b01111);
        step(0, 1, 1, 0, 0, 1);
        chk("halt_ignored", 32'(bus.halt), 32'd0);
        ret_snap = bus.retire_count;
        step(0, 1, 1, 0, 0, 0);
        chk("halt_set", 32'(bus.halt), 32'd1);
        chk("halt_en_off", 32'(bus.stage_en), 32'd0);
        chk("halt_counted", bus.retire_count - ret_snap, 32'd1);
        for (int k = 0; k < 4; k++) step(0, 1, 1, ($urandom_range(0, 1) == 1), 0, 1);
        chk("halt_frozen", bus.retire_count - ret_snap, 32'd1);

        // Saturate stall_count in overlapped mode
        step(1, 1, 1, 0, 0, 0);
        for (int i = 0; i < 65540; i++) step(0, 1, 1, 1, 0, 0);
        chk("stall_saturate", 32'(bus.stall_count), 32'hFFFF);

        // Reset mid-stream with mode changed to sequential
        step(1, 1, 0, 1, 1, 1);
        step(0, 1, 1, 0, 0, 0);
        chk("rst_valid_zero", 32'(bus.stage_valid), 32'd0);
        chk("rst_stall_zero", 32'(bus.stall_count), 32'd0);
        chk("rst_seq_en", 32'(bus.stage_en), 32'b00001);
        for (int i = 0; i < 12; i++) step(0, 1, 1, 0, 0, 0);

        // Random mix of everything, including alive drops and resets
        for (int i = 0; i < 600; i++)
            step(($urandom_range(0, 40) == 0), ($urandom_range(0, 30) != 0), 1'($urandom),
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 15) == 0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
